imem_load_controller: RTL and testbench

- Sequences and arbitrates the single-port instruction memory between the debug-unit program loader and the fetch stage.
- Accepts a byte stream from the UART debug unit, assembles big-endian 32-bit words and writes them to consecutive word addresses until the HALT word is stored.
- Otherwise passes the fetch stage's byte-addressed PC through as a word index.
- Sits between debug unit, IF stage and the instruction memory write/read port.

---
 rtl/imem_ctrl_pkg.sv | 22 ++
 rtl/imem_word_assembler.sv | 37 +++
 rtl/imem_load_controller.sv | 143 ++++++++++++++
 tb/tb_imem_load_controller.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_ctrl_pkg.sv
// Shared types and constants for the instruction-memory load controller.
// Optional feature macro: IMEM_LOAD_CHECKSUM_EN (adds an 8-bit byte checksum output).
package imem_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ASSEMBLE = 3'd1,
    ST_WRITE    = 3'd2,
    ST_DONE     = 3'd3,
    ST_ERROR    = 3'd4
  } state_t;

  localparam int          BYTES_PER_WORD    = 4;
  localparam int          BYTE_CNT_W        = 2;
  localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

  // States in which the fetch stage owns the memory address port.
  function automatic logic is_fetch_owner(state_t s);
    return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERROR);
  endfunction

endpackage

// File: rtl/imem_word_assembler.sv
// Big-endian byte-to-word assembler: shifts accepted bytes in MSB first and
// pulses o_word_valid in the cycle the last byte of a word is accepted.
module imem_word_assembler
  import imem_ctrl_pkg::*;
#(
  parameter int DATA_LENGTH = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_clear,
  input  logic                   i_accept,
  input  logic [7:0]             i_byte,
  output logic [DATA_LENGTH-1:0] o_word,
  output logic                   o_word_valid
);

  logic [BYTE_CNT_W-1:0] byte_cnt;

  // Shift register and byte counter; the counter wraps to 0 after the last byte.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!i_rst_n) begin
      byte_cnt <= '0;
      o_word   <= '0;
    end else if (i_clear) begin
      byte_cnt <= '0;
      o_word   <= '0;
    end else if (i_accept) begin
      byte_cnt <= byte_cnt + 1'b1;
      o_word   <= {o_word[DATA_LENGTH-9:0], i_byte};
    end
  end

  assign o_word_valid = i_accept && (byte_cnt == BYTE_CNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_load_controller.sv
// Instruction-memory port arbiter: loads a byte stream from the debug unit as
// big-endian words until the HALT word is stored, otherwise passes the fetch
// PC through as a word index.
// Optional feature macro: IMEM_LOAD_CHECKSUM_EN adds o_checksum, the mod-256
// sum of all bytes accepted since the last load start.
module imem_load_controller
  import imem_ctrl_pkg::*;
#(
  parameter int                     MEM_SIZE    = 1024,
  parameter int                     ADDR_LENGTH = 32,
  parameter int                     DATA_LENGTH = 32,
  parameter logic [DATA_LENGTH-1:0] HALT_WORD   = DEFAULT_HALT_WORD
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_load_start,
  input  logic                   i_byte_valid,
  input  logic [7:0]             i_byte,
  output logic                   o_byte_ready,
  input  logic                   i_fetch_req,
  input  logic [ADDR_LENGTH-1:0] i_fetch_addr,
  output logic                   o_fetch_grant,
  output logic [ADDR_LENGTH-1:0] o_mem_addr,
  output logic                   o_mem_we,
  output logic [DATA_LENGTH-1:0] o_mem_wdata,
  output logic                   o_load_busy,
  output logic                   o_load_done,
  output logic                   o_load_err,
  output logic [ADDR_LENGTH-1:0] o_word_count
`ifdef IMEM_LOAD_CHECKSUM_EN
  ,
  output logic [7:0]             o_checksum
`endif
);

  state_t                 state;
  state_t                 state_next;
  logic [ADDR_LENGTH-1:0] word_ptr;
  logic [ADDR_LENGTH-1:0] word_count;
  logic                   load_done;
  logic                   load_err;
  logic [DATA_LENGTH-1:0] asm_word;
  logic                   asm_word_valid;
  logic                   start_accept;
  logic                   byte_accept;
  logic                   word_is_halt;
  logic                   ptr_at_end;
  logic [ADDR_LENGTH-1:0] fetch_word;
  logic [ADDR_LENGTH-1:0] fetch_index;
  logic                   fetch_req_unused;

  // The fetch request is a handshake/statistics signal; it never gates the address.
  assign fetch_req_unused = i_fetch_req;

  // A start pulse only counts while the fetch stage owns the memory.
  assign start_accept = i_load_start && is_fetch_owner(state);
  assign byte_accept  = i_byte_valid && (state == ST_ASSEMBLE);
  assign word_is_halt = (asm_word == HALT_WORD);
  assign ptr_at_end   = (word_ptr == ADDR_LENGTH'(MEM_SIZE - 1));

  imem_word_assembler #(
    .DATA_LENGTH (DATA_LENGTH)
  ) u_assembler (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_clear      (start_accept),
    .i_accept     (byte_accept),
    .i_byte       (i_byte),
    .o_word       (asm_word),
    .o_word_valid (asm_word_valid)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: assigning the default first guarantees every path drives
    // state_next, so no latch is inferred.
    state_next = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (i_load_start) state_next = ST_ASSEMBLE;
      end
      ST_ASSEMBLE: begin
        if (asm_word_valid) state_next = ST_WRITE;
      end
      ST_WRITE: begin
        if (word_is_halt)    state_next = ST_DONE;
        else if (ptr_at_end) state_next = ST_ERROR;
        else                 state_next = ST_ASSEMBLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Word pointer, word counter and sticky completion flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      word_ptr   <= '0;
      word_count <= '0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else if (start_accept) begin
      word_ptr   <= '0;
      word_count <= '0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else if (state == ST_WRITE) begin
      word_count <= word_count + 1'b1;
      if (word_is_halt)    load_done <= 1'b1;
      else if (ptr_at_end) load_err  <= 1'b1;
      else                 word_ptr  <= word_ptr + 1'b1;
    end
  end

`ifdef IMEM_LOAD_CHECKSUM_EN
  // Running mod-256 sum of accepted bytes; held once the load has ended.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)          o_checksum <= '0;
    else if (start_accept) o_checksum <= '0;
    else if (byte_accept)  o_checksum <= o_checksum + i_byte;
  end
`endif

  // Fetch path: byte PC to word index, wrapped to the memory depth.
  assign fetch_word  = i_fetch_addr >> 2;
  assign fetch_index = fetch_word % ADDR_LENGTH'(MEM_SIZE);

  assign o_fetch_grant = is_fetch_owner(state);
  assign o_mem_addr    = o_fetch_grant ? fetch_index : word_ptr;
  assign o_mem_we      = (state == ST_WRITE);
  assign o_mem_wdata   = asm_word;
  assign o_byte_ready  = (state == ST_ASSEMBLE);
  assign o_load_busy   = (state == ST_ASSEMBLE) || (state == ST_WRITE);
  assign o_load_done   = load_done;
  assign o_load_err    = load_err;
  assign o_word_count  = word_count;

endmodule

// File: tb/tb_imem_load_controller.sv
// Directed bench for imem_load_controller: a 1024-word instance and a 4-word
// instance share stimulus; writes are logged per instance and compared with
// hand-computed expected words.
module tb_imem_load_controller;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_d = 8'h00;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_addr = 32'h0;

  logic        b_ready, b_grant, b_we, b_busy, b_done, b_err;
  logic [31:0] b_addr, b_wdata, b_count;
  logic        s_ready, s_grant, s_we, s_busy, s_done, s_err;
  logic [31:0] s_addr, s_wdata, s_count;
`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [7:0]  b_csum, s_csum;
`endif

  int  n_vec = 0;
  int  n_err = 0;
  wr_t b_log[$];
  wr_t s_log[$];

  always #5 clk = ~clk;

  imem_load_controller #(.MEM_SIZE(1024)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_load_start(load_start),
    .i_byte_valid(byte_valid), .i_byte(byte_d), .o_byte_ready(b_ready),
    .i_fetch_req(fetch_req), .i_fetch_addr(fetch_addr), .o_fetch_grant(b_grant),
    .o_mem_addr(b_addr), .o_mem_we(b_we), .o_mem_wdata(b_wdata),
    .o_load_busy(b_busy), .o_load_done(b_done), .o_load_err(b_err),
    .o_word_count(b_count)
`ifdef IMEM_LOAD_CHECKSUM_EN
    , .o_checksum(b_csum)
`endif
  );

  imem_load_controller #(.MEM_SIZE(4)) dut_small (
    .i_clk(clk), .i_rst_n(rst_n), .i_load_start(load_start),
    .i_byte_valid(byte_valid), .i_byte(byte_d), .o_byte_ready(s_ready),
    .i_fetch_req(fetch_req), .i_fetch_addr(fetch_addr), .o_fetch_grant(s_grant),
    .o_mem_addr(s_addr), .o_mem_we(s_we), .o_mem_wdata(s_wdata),
    .o_load_busy(s_busy), .o_load_done(s_done), .o_load_err(s_err),
    .o_word_count(s_count)
`ifdef IMEM_LOAD_CHECKSUM_EN
    , .o_checksum(s_csum)
`endif
  );

  // Record every memory write, sampled mid-cycle.
  always @(negedge clk) begin
    if (b_we === 1'b1) b_log.push_back({b_addr, b_wdata});
    if (s_we === 1'b1) s_log.push_back({s_addr, s_wdata});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte and wait (bounded) until the 1024-word instance accepts it.
  task automatic send_byte(input logic [7:0] b);
    logic acc = 1'b0;
    byte_valid = 1'b1;
    byte_d     = b;
    for (int i = 0; i < 16; i++) begin
      acc = b_ready;
      step();
      if (acc) break;
    end
    n_vec++;
    if (acc !== 1'b1) begin
      n_err++;
      $display("FAIL send_byte_timeout: byte %h accepted=%b required 1", b, acc);
    end
  endtask

  task automatic test_reset();
    fetch_addr = 32'h0000_0008;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (b_addr !== 32'd2) begin n_err++; $display("FAIL rst_addr: got %0d want 2", b_addr); end
    n_vec++; if (b_grant !== 1'b1) begin n_err++; $display("FAIL rst_grant: got %b want 1", b_grant); end
    n_vec++; if (b_we !== 1'b0) begin n_err++; $display("FAIL rst_we: got %b want 0", b_we); end
    n_vec++; if ({b_busy, b_done, b_err, b_ready} !== 4'b0) begin n_err++; $display("FAIL rst_flags: got %b want 0000", {b_busy, b_done, b_err, b_ready}); end
    n_vec++; if (b_count !== 32'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", b_count); end
    n_vec++; if (b_wdata !== 32'd0) begin n_err++; $display("FAIL rst_wdata: got %h want 0", b_wdata); end
    rst_n = 1'b1;
    step();
    n_vec++; if ({b_grant, b_busy} !== 2'b10) begin n_err++; $display("FAIL post_rst_idle: got %b want 10", {b_grant, b_busy}); end
  endtask

  task automatic test_fetch_path();
    logic [31:0] pc_tab [6] = '{32'h8, 32'hFFC, 32'h1000, 32'h1007, 32'hD, 32'h10};
    logic [31:0] big_tab[6] = '{32'd2, 32'h3FF, 32'd0, 32'd1, 32'd3, 32'd4};
    logic [31:0] sml_tab[6] = '{32'd2, 32'd3, 32'd0, 32'd1, 32'd3, 32'd0};
    for (int i = 0; i < 6; i++) begin
      fetch_addr = pc_tab[i];
      fetch_req  = i[0];
      #1;
      n_vec++; if (b_addr !== big_tab[i]) begin n_err++; $display("FAIL fetch_big[%0d]: got %h want %h", i, b_addr, big_tab[i]); end
      n_vec++; if (s_addr !== sml_tab[i]) begin n_err++; $display("FAIL fetch_small[%0d]: got %h want %h", i, s_addr, sml_tab[i]); end
    end
    step();
  endtask

  task automatic test_basic_load();
    logic [7:0] bytes[8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    wr_t        exp[2]   = '{{32'd0, 32'h1234_5678}, {32'd1, 32'hFFFF_FFFF}};
    wr_t        got;
    b_log.delete(); s_log.delete();
    fetch_req  = 1'b1;
    fetch_addr = 32'h14;
    load_start = 1'b1;
    #1;
    n_vec++; if ({b_grant, b_addr} !== {1'b1, 32'd5}) begin n_err++; $display("FAIL start_cycle_fetch: got %b/%0d want 1/5", b_grant, b_addr); end
    step();
    load_start = 1'b0;
    n_vec++; if ({b_grant, b_busy, b_ready} !== 3'b011) begin n_err++; $display("FAIL assemble_entry: got %b want 011", {b_grant, b_busy, b_ready}); end
    n_vec++; if (b_addr !== 32'd0) begin n_err++; $display("FAIL assemble_addr: got %0d want 0", b_addr); end
    for (int i = 0; i < 8; i++) begin
      load_start = (i == 2);   // start during a load must be ignored
      send_byte(bytes[i]);
    end
    load_start = 1'b0;
    byte_valid = 1'b0;
    step(); step();
    n_vec++; if (b_log.size() !== 2) begin n_err++; $display("FAIL basic_nwrites: got %0d want 2", b_log.size()); end
    for (int i = 0; i < 2; i++) begin
      got = (i < b_log.size()) ? b_log[i] : '0;
      n_vec++; if (got !== exp[i]) begin n_err++; $display("FAIL basic_write[%0d]: got %h want %h", i, got, exp[i]); end
    end
    n_vec++; if ({b_done, b_err, b_busy, b_grant} !== 4'b1001) begin n_err++; $display("FAIL basic_flags: got %b want 1001", {b_done, b_err, b_busy, b_grant}); end
    n_vec++; if (b_count !== 32'd2) begin n_err++; $display("FAIL basic_count: got %0d want 2", b_count); end
    n_vec++; if (b_addr !== 32'd5) begin n_err++; $display("FAIL basic_fetch_back: got %0d want 5", b_addr); end
  endtask

  task automatic test_valid_toggle();
    logic [7:0] bytes[8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    wr_t        exp[2]   = '{{32'd0, 32'h1234_5678}, {32'd1, 32'hFFFF_FFFF}};
    wr_t        got;
    b_log.delete(); s_log.delete();
    load_start = 1'b1;          // restart from DONE
    step();
    load_start = 1'b0;
    n_vec++; if ({b_done, b_err, b_busy} !== 3'b001) begin n_err++; $display("FAIL restart_flags: got %b want 001", {b_done, b_err, b_busy}); end
    n_vec++; if (b_count !== 32'd0) begin n_err++; $display("FAIL restart_count: got %0d want 0", b_count); end
    for (int i = 0; i < 8; i++) begin
      send_byte(bytes[i]);
      byte_valid = 1'b0;
      byte_d     = 8'hEE;       // junk while not valid
      step();
    end
    step();
    n_vec++; if (b_log.size() !== 2) begin n_err++; $display("FAIL toggle_nwrites: got %0d want 2", b_log.size()); end
    for (int i = 0; i < 2; i++) begin
      got = (i < b_log.size()) ? b_log[i] : '0;
      n_vec++; if (got !== exp[i]) begin n_err++; $display("FAIL toggle_write[%0d]: got %h want %h", i, got, exp[i]); end
    end
    n_vec++; if ({b_done, b_count} !== {1'b1, 32'd2}) begin n_err++; $display("FAIL toggle_done: got %b/%0d want 1/2", b_done, b_count); end
  endtask

  task automatic test_reset_mid_load();
    logic [7:0] first[6]  = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2};
    logic [7:0] second[8] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    wr_t        exp[2]    = '{{32'd0, 32'hAABB_CCDD}, {32'd1, 32'hFFFF_FFFF}};
    wr_t        got;
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    for (int i = 0; i < 6; i++) send_byte(first[i]);
    n_vec++; if (b_count !== 32'd1) begin n_err++; $display("FAIL midload_count: got %0d want 1", b_count); end
    rst_n = 1'b0;
    #1;
    n_vec++; if ({b_busy, b_ready, b_grant, b_done} !== 4'b0010) begin n_err++; $display("FAIL midload_rst_flags: got %b want 0010", {b_busy, b_ready, b_grant, b_done}); end
    n_vec++; if (b_count !== 32'd0) begin n_err++; $display("FAIL midload_rst_count: got %0d want 0", b_count); end
    byte_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    b_log.delete(); s_log.delete();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    for (int i = 0; i < 8; i++) send_byte(second[i]);
    byte_valid = 1'b0;
    step(); step();
    n_vec++; if (b_log.size() !== 2) begin n_err++; $display("FAIL reload_nwrites: got %0d want 2", b_log.size()); end
    for (int i = 0; i < 2; i++) begin
      got = (i < b_log.size()) ? b_log[i] : '0;
      n_vec++; if (got !== exp[i]) begin n_err++; $display("FAIL reload_write[%0d]: got %h want %h", i, got, exp[i]); end
    end
    n_vec++; if (b_done !== 1'b1) begin n_err++; $display("FAIL reload_done: got %b want 1", b_done); end
  endtask

`ifdef IMEM_LOAD_CHECKSUM_EN
  task automatic test_checksum();
    logic [7:0] bytes[12] = '{8'h01, 8'h02, 8'h03, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFC,
                              8'hFF, 8'hFF, 8'hFF, 8'hFF};
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    n_vec++; if (b_csum !== 8'h00) begin n_err++; $display("FAIL csum_start: got %h want 00", b_csum); end
    for (int i = 0; i < 12; i++) begin
      send_byte(bytes[i]);
      if (i == 3) begin
        n_vec++; if (b_csum !== 8'h05) begin n_err++; $display("FAIL csum_word0: got %h want 05", b_csum); end
      end
    end
    byte_valid = 1'b0;
    step(); step();
    n_vec++; if (b_csum !== 8'hFA) begin n_err++; $display("FAIL csum_final: got %h want fa", b_csum); end
    n_vec++; if ({b_done, b_count} !== {1'b1, 32'd3}) begin n_err++; $display("FAIL csum_done: got %b/%0d want 1/3", b_done, b_count); end
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    n_vec++; if (b_csum !== 8'h00) begin n_err++; $display("FAIL csum_restart: got %h want 00", b_csum); end
  endtask
`endif

  task automatic test_overflow();
    logic [7:0] bytes[16] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
                              8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hF0, 8'h01};
    wr_t        exp[4]    = '{{32'd0, 32'h1122_3344}, {32'd1, 32'h5566_7788},
                              {32'd2, 32'h99AA_BBCC}, {32'd3, 32'hDDEE_F001}};
    wr_t        got;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    s_log.delete(); b_log.delete();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    for (int i = 0; i < 16; i++) send_byte(bytes[i]);
    byte_valid = 1'b0;
    step(); step();
    n_vec++; if (s_log.size() !== 4) begin n_err++; $display("FAIL ovf_nwrites: got %0d want 4", s_log.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (i < s_log.size()) ? s_log[i] : '0;
      n_vec++; if (got !== exp[i]) begin n_err++; $display("FAIL ovf_write[%0d]: got %h want %h", i, got, exp[i]); end
    end
    n_vec++; if ({s_err, s_done, s_busy, s_grant} !== 4'b1001) begin n_err++; $display("FAIL ovf_flags: got %b want 1001", {s_err, s_done, s_busy, s_grant}); end
    n_vec++; if (s_count !== 32'd4) begin n_err++; $display("FAIL ovf_count: got %0d want 4", s_count); end
    n_vec++; if ({b_busy, b_err, b_count} !== {2'b10, 32'd4}) begin n_err++; $display("FAIL big_no_ovf: got %b%b/%0d want 10/4", b_busy, b_err, b_count); end
    // Bytes offered while in ERROR must be ignored.
    byte_valid = 1'b1;
    byte_d     = 8'h5A;
    n_vec++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL ovf_ready: got %b want 0", s_ready); end
    repeat (6) step();
    byte_valid = 1'b0;
    n_vec++; if (s_log.size() !== 4) begin n_err++; $display("FAIL ovf_no_5th_write: got %0d want 4", s_log.size()); end
  endtask

  initial begin
    test_reset();
    test_fetch_path();
    test_basic_load();
    test_valid_toggle();
    test_reset_mid_load();
`ifdef IMEM_LOAD_CHECKSUM_EN
    test_checksum();
`endif
    test_overflow();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", n_vec);
    $fatal(1, "watchdog");
  end

endmodule
